muldiv_iter: RTL



---
 rtl/muldiv_pkg.sv | 25 ++
 rtl/muldiv_if.sv | 24 ++
 rtl/muldiv_step.sv | 31 +++
 rtl/muldiv_iter.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared op encodings, datapath step modes and FSM states for the iterative mult/div unit.
package muldiv_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  localparam logic MODE_MUL = 1'b0;
  localparam logic MODE_DIV = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    MUL,
    DIV,
    FIN,
    DZ
  } stateT;

  // op[0] clear selects the signed flavour of both MULT and DIV
  function automatic logic isSignedOp(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/result bundle between the control unit (master) and the mult/div unit (slave).
interface muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             div0;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b,
    input  busy, done, div0, hi, lo
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, div0, hi, lo
  );
endinterface

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add multiply or restoring-divide step on a 2*WIDTH accumulator.
// Purely combinational; {rem, quotient} or {product-hi, multiplier} layout in acc.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic               divMode,
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   opnd,
  output logic [2*WIDTH-1:0] accNext
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  always_comb begin
    sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
    shifted = acc[2*WIDTH-1:WIDTH-1];
    diff    = shifted - {1'b0, opnd};
    accNext = {sum, acc[WIDTH-1:1]};
    if (divMode) begin
      // remainder stays below the divisor, so a set top bit of diff can only mean a borrow
      if (!diff[WIDTH]) begin
        accNext = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      end else begin
        accNext = {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/muldiv_iter.sv
// Iterative signed/unsigned MULT/DIV for the HI/LO slot; done WIDTH+1 cycles after start (1 for div0).
// No backpressure: start is honoured only in IDLE, ignored otherwise; results held until next completion.
module muldiv_iter
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     reset,
  muldiv_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  stateT              state;
  stateT              stateNext;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] accNext;
  logic [WIDTH-1:0]   opnd;
  logic               divMode;
  logic               negLo;
  logic               negHi;
  logic [WIDTH-1:0]   hiReg;
  logic [WIDTH-1:0]   loReg;
  logic               doneReg;
  logic               div0Reg;

  logic               signedOp;
  logic               lastIter;
  logic               setDone;
  logic               setDiv0;
  logic [WIDTH-1:0]   magA;
  logic [WIDTH-1:0]   magB;
  logic [2*WIDTH-1:0] prodFinal;
  logic [WIDTH-1:0]   quotFinal;
  logic [WIDTH-1:0]   remFinal;

  assign signedOp = isSignedOp(bus.op);
  // |-2^(W-1)| = 2^(W-1) still fits as an unsigned W-bit magnitude
  assign magA     = (signedOp && bus.a[WIDTH-1]) ? -bus.a : bus.a;
  assign magB     = (signedOp && bus.b[WIDTH-1]) ? -bus.b : bus.b;
  assign lastIter = (cnt == LAST_ITER);

  assign prodFinal = negLo ? -acc : acc;
  assign quotFinal = negLo ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign remFinal  = negHi ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

  muldiv_step #(.WIDTH(WIDTH)) uStep (
    .divMode (divMode),
    .acc     (acc),
    .opnd    (opnd),
    .accNext (accNext)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    setDone   = 1'b0;
    setDiv0   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          if (!bus.op[1]) begin
            stateNext = MUL;
          end else if (bus.b == '0) begin
            stateNext = DZ;
          end else begin
            stateNext = DIV;
          end
        end
      end
      MUL, DIV: begin
        if (lastIter) begin
          stateNext = FIN;
        end
      end
      FIN: begin
        stateNext = IDLE;
        setDone   = 1'b1;
      end
      DZ: begin
        stateNext = IDLE;
        setDone   = 1'b1;
        setDiv0   = 1'b1;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      acc     <= '0;
      opnd    <= '0;
      divMode <= MODE_MUL;
      negLo   <= 1'b0;
      negHi   <= 1'b0;
      hiReg   <= '0;
      loReg   <= '0;
      doneReg <= 1'b0;
      div0Reg <= 1'b0;
    end else begin
      doneReg <= setDone;
      div0Reg <= setDiv0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            cnt     <= '0;
            divMode <= bus.op[1] ? MODE_DIV : MODE_MUL;
            opnd    <= magB;
            acc     <= {{WIDTH{1'b0}}, magA};
            // negLo: product/quotient sign; negHi: remainder follows the dividend
            negLo   <= signedOp && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            negHi   <= signedOp && (bus.op[1] ? bus.a[WIDTH-1]
                                              : (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]));
          end
        end
        MUL, DIV: begin
          acc <= accNext;
          cnt <= cnt + 1'b1;
        end
        FIN: begin
          if (divMode == MODE_MUL) begin
            hiReg <= prodFinal[2*WIDTH-1:WIDTH];
            loReg <= prodFinal[WIDTH-1:0];
          end else begin
            hiReg <= remFinal;
            loReg <= quotFinal;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (state != IDLE);
  assign bus.done = doneReg;
  assign bus.div0 = div0Reg;
  assign bus.hi   = hiReg;
  assign bus.lo   = loReg;

endmodule
